// File: rtl/conv2d_frame_ctrl_if.sv
// Handshake and bus bundle that links the frame sequencer to the frame RAMs and the conv engine.
// The sequencer uses the master modport; the RAM/engine side uses slave.
interface conv2d_frame_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  conv_rst;
    logic                  conv_valid_in;
    logic [DATA_WIDTH-1:0] conv_data_in;
    logic                  conv_valid_out;
    logic [DATA_WIDTH-1:0] conv_data_out;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;

    modport master (
        input  start, rd_data, conv_valid_out, conv_data_out, wr_ready,
        output busy, done, rd_en, rd_addr, conv_rst, conv_valid_in, conv_data_in,
               wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_data, conv_valid_out, conv_data_out, wr_ready,
        input  busy, done, rd_en, rd_addr, conv_rst, conv_valid_in, conv_data_in,
               wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/conv2d_frame_ctrl.sv
// Frame sequencer for a 3x3 conv engine: streams N pixels in, writes M results out, pulses done.
// Optional macro CONV_CTRL_PERF_EN adds stall_cycles / frame_cycles performance counters.
module conv2d_frame_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 100,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                Clk,
    input  logic                Rst,
    conv2d_frame_ctrl_if.master bus
`ifdef CONV_CTRL_PERF_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         frame_cycles
`endif
);
    localparam int N  = IMG_SIZE * IMG_SIZE;
    localparam int M  = (IMG_SIZE - 2) * (IMG_SIZE - 2);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         N_C      = CW'(N);
    localparam logic [CW-1:0]         M_C      = CW'(M);
    localparam logic [ADDR_WIDTH-1:0] WR_LAST  = ADDR_WIDTH'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FINISH
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_issued;
    logic [CW-1:0]         r_results;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_rd_pend;
    logic [DATA_WIDTH-1:0] r_pix;
    logic                  r_pix_v;
    logic                  r_acc_d;
    logic                  r_wr_pend;

    logic                  w_run;
    logic                  w_rd_en;
    logic                  w_strobe;
    logic                  w_wr_en;
    logic                  w_wr_acc;
    logic                  w_last_wr;

    assign w_run = (r_state == S_RUN);

    // One read in flight at a time: the pixel register is then always empty when data lands.
    assign w_rd_en   = w_run && (r_issued < N_C) && bus.wr_ready && !r_rd_pend;
    assign w_strobe  = w_run && r_pix_v && bus.wr_ready;
    assign w_wr_en   = (r_acc_d && bus.conv_valid_out) || r_wr_pend;
    assign w_wr_acc  = w_wr_en && bus.wr_ready;
    assign w_last_wr = w_wr_acc && (r_results == M_C - CW'(1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_next = S_CLEAR;
            S_CLEAR:  w_state_next = S_RUN;
            S_RUN:    if (w_last_wr) w_state_next = S_FINISH;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_issued  <= '0;
            r_results <= '0;
            r_wr_addr <= '0;
            r_rd_pend <= 1'b0;
            r_pix     <= '0;
            r_pix_v   <= 1'b0;
            r_acc_d   <= 1'b0;
            r_wr_pend <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_CLEAR) begin
                r_issued  <= '0;
                r_results <= '0;
                r_wr_addr <= '0;
                r_rd_pend <= 1'b0;
                r_pix_v   <= 1'b0;
                r_acc_d   <= 1'b0;
                r_wr_pend <= 1'b0;
            end else begin
                if (w_rd_en) begin
                    r_issued <= r_issued + CW'(1);
                end
                r_rd_pend <= w_rd_en;
                if (r_rd_pend) begin
                    r_pix   <= bus.rd_data;
                    r_pix_v <= 1'b1;
                end else if (w_strobe) begin
                    r_pix_v <= 1'b0;
                end
                r_acc_d   <= w_strobe;
                r_wr_pend <= w_wr_en && !bus.wr_ready;
                if (w_wr_acc && (r_results < M_C)) begin
                    r_results <= r_results + CW'(1);
                    r_wr_addr <= (r_wr_addr == WR_LAST) ? '0 : r_wr_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = (r_state == S_FINISH);
    assign bus.rd_en         = w_rd_en;
    assign bus.rd_addr       = r_issued[ADDR_WIDTH-1:0];
    assign bus.conv_rst      = Rst || (r_state == S_CLEAR);
    assign bus.conv_valid_in = w_strobe;
    assign bus.conv_data_in  = r_pix;
    // Engine registers only move on conv_valid_in, so its output is stable while a write waits.
    assign bus.wr_en         = w_wr_en;
    assign bus.wr_addr       = r_wr_addr;
    assign bus.wr_data       = bus.conv_data_out;

`ifdef CONV_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_frame_cycles;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_stall_cycles <= '0;
            r_frame_cycles <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_stall_cycles <= '0;
            r_frame_cycles <= '0;
        end else begin
            if (w_run && !bus.wr_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if ((r_state != S_IDLE) && (r_frame_cycles != 32'hFFFF_FFFF)) begin
                r_frame_cycles <= r_frame_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign frame_cycles = r_frame_cycles;
`endif

endmodule

// File: tb/tb_conv2d_frame_ctrl.sv
// Directed bench for conv2d_frame_ctrl on a 4x4 image with a RAM model and an ideal 3x3 summing engine.
module tb_conv2d_frame_ctrl;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int IMG = 4;
    localparam int N   = IMG * IMG;
    localparam int M   = (IMG - 2) * (IMG - 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv2d_frame_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef CONV_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] frame_cycles;
`endif

    conv2d_frame_ctrl #(
        .DATA_WIDTH(DW),
        .IMG_SIZE  (IMG),
        .ADDR_WIDTH(AW)
    ) dut (
        .Clk         (clk),
        .Rst         (rst),
        .bus         (bus)
`ifdef CONV_CTRL_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .frame_cycles(frame_cycles)
`endif
    );

    // Golden window sums: ram[i]=i and ram[i]=i*i
    int exp_lin[M] = '{45, 54, 81, 90};
    int exp_sq[M]  = '{327, 426, 831, 1002};

    int checks   = 0;
    int failures = 0;

    // Input RAM: registered read, data valid the cycle after rd_en.
    logic [DW-1:0] ram [N];
    always @(posedge clk) begin
        if (bus.rd_en === 1'b1) bus.rd_data <= ram[bus.rd_addr];
    end

    // Ideal engine: frozen unless strobed, emits the 3x3 window sum ending at each pixel.
    logic [DW-1:0] eng_img [N];
    int eng_cnt = 0;
    always @(posedge clk) begin : engine
        int r;
        int c;
        logic [DW-1:0] s;
        if (bus.conv_rst === 1'b1) begin
            eng_cnt <= 0;
            bus.conv_valid_out <= 1'b0;
            bus.conv_data_out  <= '0;
        end else if (bus.conv_valid_in === 1'b1 && eng_cnt < N) begin
            r = eng_cnt / IMG;
            c = eng_cnt % IMG;
            eng_img[eng_cnt] = bus.conv_data_in;
            s = '0;
            if (r >= 2 && c >= 2) begin
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        s = s + eng_img[(r - dr) * IMG + (c - dc)];
                bus.conv_data_out <= s;
            end
            bus.conv_valid_out <= (r >= 2 && c >= 2);
            eng_cnt <= eng_cnt + 1;
        end
    end

    // Negedge monitor: event counters and a log of accepted writes.
    int n_rd = 0, n_cvi = 0, n_done = 0, n_wr = 0, n_crst = 0;
    int rd_seq_err = 0, busy_err = 0, exp_rd = 0;
    logic prev_done = 1'b0;
    logic [AW-1:0] wlog_addr [$];
    logic [DW-1:0] wlog_data [$];
    always @(negedge clk) begin
        if (bus.conv_rst === 1'b1) begin
            exp_rd = 0;
            n_crst++;
        end
        if (bus.rd_en === 1'b1) begin
            n_rd++;
            if (bus.rd_addr !== AW'(exp_rd) || exp_rd >= N) rd_seq_err++;
            exp_rd++;
        end
        if (bus.conv_valid_in === 1'b1) n_cvi++;
        if (bus.done === 1'b1) n_done++;
        if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
            n_wr++;
            wlog_addr.push_back(bus.wr_addr);
            wlog_data.push_back(bus.wr_data);
        end
        if (prev_done === 1'b1 && bus.busy === 1'b1) busy_err++;
        prev_done = bus.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ram(input int sq);
        for (int i = 0; i < N; i++) ram[i] = sq ? DW'(i * i) : DW'(i);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // mode 0: wr_ready untouched; 1: toggle each cycle; 2: low for cycles 10..12
    task automatic run_to_done(input int mode, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (mode == 1) bus.wr_ready = ~bus.wr_ready;
            if (mode == 2) bus.wr_ready = !(i >= 10 && i < 13);
            @(negedge clk);
            if (bus.done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int rd0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.wr_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (bus.conv_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_conv_rst: got %b expected 1", bus.conv_rst);
        end
        checks++;
        if ({bus.busy, bus.done, bus.rd_en, bus.conv_valid_in, bus.wr_en} !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {bus.busy, bus.done, bus.rd_en, bus.conv_valid_in, bus.wr_en});
        end
        checks++;
        if (bus.rd_addr !== '0 || bus.wr_addr !== '0) begin
            failures++;
            $display("FAIL reset_addrs: got rd=%0d wr=%0d expected 0 0", bus.rd_addr, bus.wr_addr);
        end
        tick();
        rst = 1'b0;
        rd0 = n_rd;
        repeat (20) tick();
        @(negedge clk);
        checks++;
        if (bus.conv_rst !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_state: got conv_rst=%b busy=%b expected 0 0", bus.conv_rst, bus.busy);
        end
        checks++;
        if (n_rd != rd0) begin
            failures++;
            $display("FAIL idle_no_read: got %0d reads expected 0", n_rd - rd0);
        end
        tick();
    endtask

    task automatic test_frame();
        int rd0, cvi0, wr0, dn0, wi0, se0;
        bit timed_out;
        fill_ram(0);
        rd0 = n_rd; cvi0 = n_cvi; wr0 = n_wr; dn0 = n_done; wi0 = wlog_addr.size(); se0 = rd_seq_err;
        bus.wr_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.conv_rst !== 1'b1 || bus.rd_en !== 1'b0) begin
            failures++;
            $display("FAIL frame_clear: got busy=%b conv_rst=%b rd_en=%b expected 1 1 0",
                     bus.busy, bus.conv_rst, bus.rd_en);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.rd_en !== 1'b1 || bus.rd_addr !== '0) begin
            failures++;
            $display("FAIL frame_first_read: got rd_en=%b addr=%0d expected 1 0", bus.rd_en, bus.rd_addr);
        end
        tick();
        run_to_done(0, timed_out);
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL frame_timeout: got no done expected done within 400 cycles");
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_busy_after_done: got %b expected 0", bus.busy);
        end
        repeat (3) tick();
        checks++;
        if (n_done - dn0 != 1 || busy_err != 0) begin
            failures++;
            $display("FAIL frame_done_count: got %0d (busy_err=%0d) expected 1", n_done - dn0, busy_err);
        end
        checks++;
        if (n_rd - rd0 != N || rd_seq_err != se0) begin
            failures++;
            $display("FAIL frame_reads: got %0d seq_err=%0d expected %0d 0", n_rd - rd0, rd_seq_err - se0, N);
        end
        checks++;
        if (n_cvi - cvi0 != N || n_wr - wr0 != M) begin
            failures++;
            $display("FAIL frame_counts: got cvi=%0d wr=%0d expected %0d %0d", n_cvi - cvi0, n_wr - wr0, N, M);
        end
        if (wlog_addr.size() >= wi0 + M) begin
            for (int k = 0; k < M; k++) begin
                checks++;
                if (wlog_addr[wi0+k] !== AW'(k) || wlog_data[wi0+k] !== DW'(exp_lin[k])) begin
                    failures++;
                    $display("FAIL frame_write%0d: got addr=%0d data=%0d expected addr=%0d data=%0d",
                             k, wlog_addr[wi0+k], wlog_data[wi0+k], k, exp_lin[k]);
                end
            end
        end
    endtask

    task automatic test_toggle();
        int rd0, cvi0, wr0, wi0;
        bit timed_out;
        fill_ram(1);
        rd0 = n_rd; cvi0 = n_cvi; wr0 = n_wr; wi0 = wlog_addr.size();
        bus.wr_ready = 1'b1;
        pulse_start();
        run_to_done(1, timed_out);
        tick();
        bus.wr_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL toggle_timeout: got no done expected done within 400 cycles");
        end
        checks++;
        if (n_rd - rd0 != N || n_cvi - cvi0 != N || n_wr - wr0 != M) begin
            failures++;
            $display("FAIL toggle_counts: got rd=%0d cvi=%0d wr=%0d expected %0d %0d %0d",
                     n_rd - rd0, n_cvi - cvi0, n_wr - wr0, N, N, M);
        end
        if (wlog_addr.size() >= wi0 + M) begin
            for (int k = 0; k < M; k++) begin
                checks++;
                if (wlog_addr[wi0+k] !== AW'(k) || wlog_data[wi0+k] !== DW'(exp_sq[k])) begin
                    failures++;
                    $display("FAIL toggle_write%0d: got addr=%0d data=%0d expected addr=%0d data=%0d",
                             k, wlog_addr[wi0+k], wlog_data[wi0+k], k, exp_sq[k]);
                end
            end
        end
    endtask

    task automatic test_stall_and_restart();
        int rd0, cvi0, wr0, dn0, cr0, wi0, bad_hold, bad_strobe;
        bit stalled, timed_out;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        fill_ram(1);
        rd0 = n_rd; cvi0 = n_cvi; wr0 = n_wr; dn0 = n_done; cr0 = n_crst; wi0 = wlog_addr.size();
        bus.wr_ready = 1'b1;
        pulse_start();
        stalled = 1'b0; timed_out = 1'b1; bad_hold = 0; bad_strobe = 0;
        a0 = '0; d0 = '0;
        for (int i = 0; i < 400; i++) begin
            bus.start = (i == 3 || i == 20);
            if (!stalled && bus.wr_en === 1'b1 && n_wr - wr0 == 1) begin
                stalled = 1'b1;
                a0 = bus.wr_addr;
                d0 = bus.wr_data;
                bus.wr_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (bus.wr_en !== 1'b1 || bus.wr_addr !== a0 || bus.wr_data !== d0) bad_hold++;
                    if (bus.conv_valid_in !== 1'b0 || bus.rd_en !== 1'b0) bad_strobe++;
                    tick();
                end
                bus.wr_ready = 1'b1;
            end
            @(negedge clk);
            if (bus.done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        bus.start = 1'b0;
        repeat (3) tick();
        checks++;
        if (timed_out || !stalled) begin
            failures++;
            $display("FAIL stall_run: got timeout=%b stalled=%b expected 0 1", timed_out, stalled);
        end
        checks++;
        if (bad_hold != 0 || a0 !== AW'(1) || d0 !== DW'(exp_sq[1])) begin
            failures++;
            $display("FAIL stall_hold: got bad=%0d addr=%0d data=%0d expected 0 1 %0d",
                     bad_hold, a0, d0, exp_sq[1]);
        end
        checks++;
        if (bad_strobe != 0) begin
            failures++;
            $display("FAIL stall_no_strobe: got %0d strobed cycles expected 0", bad_strobe);
        end
        checks++;
        if (n_crst - cr0 != 1 || n_done - dn0 != 1) begin
            failures++;
            $display("FAIL restart_ignored: got clears=%0d dones=%0d expected 1 1", n_crst - cr0, n_done - dn0);
        end
        checks++;
        if (n_rd - rd0 != N || n_cvi - cvi0 != N || n_wr - wr0 != M) begin
            failures++;
            $display("FAIL stall_counts: got rd=%0d cvi=%0d wr=%0d expected %0d %0d %0d",
                     n_rd - rd0, n_cvi - cvi0, n_wr - wr0, N, N, M);
        end
        if (wlog_addr.size() >= wi0 + M) begin
            for (int k = 0; k < M; k++) begin
                checks++;
                if (wlog_addr[wi0+k] !== AW'(k) || wlog_data[wi0+k] !== DW'(exp_sq[k])) begin
                    failures++;
                    $display("FAIL stall_write%0d: got addr=%0d data=%0d expected addr=%0d data=%0d",
                             k, wlog_addr[wi0+k], wlog_data[wi0+k], k, exp_sq[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int cvi0, dn0, rd0, wr0, wi0;
        bit hit, timed_out;
        fill_ram(0);
        cvi0 = n_cvi; dn0 = n_done;
        bus.wr_ready = 1'b1;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (n_cvi - cvi0 >= 7) begin
                hit = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (!hit || bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got hit=%b busy=%b rd_en=%b wr_en=%b expected 1 0 0 0",
                     hit, bus.busy, bus.rd_en, bus.wr_en);
        end
        rd0 = n_rd;
        repeat (30) tick();
        checks++;
        if (n_done != dn0 || n_rd != rd0) begin
            failures++;
            $display("FAIL abort_quiet: got dones=%0d reads=%0d expected 0 0", n_done - dn0, n_rd - rd0);
        end
        fill_ram(1);
        rd0 = n_rd; cvi0 = n_cvi; wr0 = n_wr; wi0 = wlog_addr.size();
        pulse_start();
        run_to_done(0, timed_out);
        repeat (3) tick();
        checks++;
        if (timed_out || n_rd - rd0 != N || n_cvi - cvi0 != N || n_wr - wr0 != M) begin
            failures++;
            $display("FAIL after_abort_counts: got timeout=%b rd=%0d cvi=%0d wr=%0d expected 0 %0d %0d %0d",
                     timed_out, n_rd - rd0, n_cvi - cvi0, n_wr - wr0, N, N, M);
        end
        if (wlog_addr.size() >= wi0 + M) begin
            for (int k = 0; k < M; k++) begin
                checks++;
                if (wlog_addr[wi0+k] !== AW'(k) || wlog_data[wi0+k] !== DW'(exp_sq[k])) begin
                    failures++;
                    $display("FAIL after_abort_write%0d: got addr=%0d data=%0d expected addr=%0d data=%0d",
                             k, wlog_addr[wi0+k], wlog_data[wi0+k], k, exp_sq[k]);
                end
            end
        end
    endtask

`ifdef CONV_CTRL_PERF_EN
    task automatic test_perf();
        logic [31:0] fc1;
        bit timed_out;
        fill_ram(0);
        bus.wr_ready = 1'b1;
        pulse_start();
        run_to_done(2, timed_out);
        bus.wr_ready = 1'b1;
        repeat (4) tick();
        fc1 = frame_cycles;
        checks++;
        if (timed_out || stall_cycles !== 32'd3) begin
            failures++;
            $display("FAIL perf_stall: got timeout=%b stall=%0d expected 0 3", timed_out, stall_cycles);
        end
        checks++;
        if (fc1 == 32'd0) begin
            failures++;
            $display("FAIL perf_frame_nonzero: got %0d expected nonzero", fc1);
        end
        pulse_start();
        run_to_done(2, timed_out);
        bus.wr_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (frame_cycles !== fc1 || stall_cycles !== 32'd3) begin
            failures++;
            $display("FAIL perf_repeat: got frame=%0d stall=%0d expected %0d 3", frame_cycles, stall_cycles, fc1);
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.wr_ready = 1'b1;
        fill_ram(0);
        test_reset();
        test_frame();
        test_toggle();
        test_stall_and_restart();
        test_reset_mid();
`ifdef CONV_CTRL_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
